// File: rtl/essential_bit_sequencer.sv
// Essential-bit sequencer: takes one 16-bit essential-bit mask per transaction
// and emits the position of every set bit, MSB-first, one beat per accepted
// out_valid/out_ready handshake, to the bit-serial shift-add PE.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    upstream mask handshake (in_mask, in_tag)
//   out_valid/out_ready  downstream beat handshake
//   out_pos              bit position of the current beat (15..0)
//   out_last             final beat of the current mask
//   out_zero             mask was all-zero (single beat emitted)
//   out_tag              tag of the mask being sequenced
//   out_idx              0-based beat index within the mask
//   busy                 high while a mask is being sequenced
module essential_bit_sequencer #(
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_mask,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_pos,
  output logic             out_last,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_idx,
  output logic             busy
);

  localparam int unsigned MASK_W = 16;
  localparam int unsigned POS_W  = 4;
  localparam int unsigned IDX_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                zero_q, zero_d;

  logic [POS_W-1:0]    pos_c;
  logic                onehot_c;
  logic                scan_c;
  logic                last_c;
  logic                load_c;
  logic                beat_c;

  // Highest set bit of the working mask; 0 when the mask is empty.
  always_comb begin
    pos_c = '0;
    for (int i = 0; i < int'(MASK_W); i++) begin
      if (wmask_q[i]) pos_c = POS_W'(i);
    end
  end

  // Exactly one bit left means this beat is the last one.
  assign onehot_c = (wmask_q != '0) &&
                    ((wmask_q & (wmask_q - MASK_W'(1))) == '0);

  assign scan_c = (state_q == SCAN);
  assign last_c = scan_c & (zero_q | onehot_c);
  assign beat_c = scan_c & out_ready;

  // Accept a new mask when idle or while the last beat is retiring.
  assign in_ready = ~scan_c | (beat_c & last_c);
  assign load_c   = in_valid & in_ready;

  // Outputs depend on registers only; gated so idle presents zeros.
  assign out_valid = scan_c;
  assign busy      = scan_c;
  assign out_pos   = pos_c;
  assign out_last  = last_c;
  assign out_zero  = scan_c & zero_q;
  assign out_tag   = scan_c ? tag_q : '0;
  assign out_idx   = scan_c ? idx_q : '0;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    wmask_d = wmask_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    zero_d  = zero_q;
    if (load_c) begin
      state_d = SCAN;
      wmask_d = in_mask;
      tag_d   = in_tag;
      idx_d   = '0;
      zero_d  = (in_mask == '0);
    end else if (beat_c && !last_c) begin
      wmask_d = wmask_q & ~(MASK_W'(1) << pos_c);
      idx_d   = idx_q + IDX_W'(1);
    end else if (beat_c && last_c) begin
      state_d = IDLE;
      wmask_d = '0;
    end
  end

  // State and working registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wmask_q <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wmask_q <= wmask_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_essential_bit_sequencer.sv
// Directed bench for essential_bit_sequencer: a vector table for the
// single-mask cases plus hand-written back-to-back and reset sequences.
module tb_essential_bit_sequencer;

  localparam int unsigned TAG_W = 8;
  localparam int unsigned NVEC  = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_mask;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_pos;
  logic             out_last;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       out_idx;
  logic             busy;

  int n_checks;
  int n_fail;

  essential_bit_sequencer #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_last  (out_last),
    .out_zero  (out_zero),
    .out_tag   (out_tag),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] m;
    logic [7:0]  t;
    logic        ordy;
    logic        ev;
    logic [3:0]  ep;
    logic        el;
    logic        ez;
    logic [4:0]  ei;
    logic [7:0]  et;
    logic        eir;
    logic        eb;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(logic iv, logic [15:0] m, logic [7:0] t, logic ordy,
                              logic ev, logic [3:0] ep, logic el, logic ez,
                              logic [4:0] ei, logic [7:0] et, logic eir, logic eb);
    vec_t v;
    v.iv = iv; v.m = m; v.t = t; v.ordy = ordy;
    v.ev = ev; v.ep = ep; v.el = el; v.ez = ez;
    v.ei = ei; v.et = et; v.eir = eir; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] m, input logic [7:0] t, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_mask   = m;
    in_tag    = t;
    out_ready = ordy;
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, ".valid"}, 32'(out_valid), 32'd0);
    check({name, ".busy"},  32'(busy),      32'd0);
    check({name, ".ready"}, 32'(in_ready),  32'd1);
    check({name, ".pos"},   32'(out_pos),   32'd0);
    check({name, ".last"},  32'(out_last),  32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mask   = '0;
    in_tag    = '0;
    out_ready = 1'b0;

    // iv  mask     tag    ordy | v  pos   last zero idx    tag    ird  busy
    vecs[0]  = mk(0, 16'h0000, 8'h00, 0,  0, 4'd0,  0, 0, 5'd0, 8'h00, 1, 0);
    vecs[1]  = mk(1, 16'h8421, 8'h3C, 1,  0, 4'd0,  0, 0, 5'd0, 8'h00, 1, 0);
    vecs[2]  = mk(0, 16'h0000, 8'h00, 1,  1, 4'd15, 0, 0, 5'd0, 8'h3C, 0, 1);
    vecs[3]  = mk(0, 16'h0000, 8'h00, 0,  1, 4'd10, 0, 0, 5'd1, 8'h3C, 0, 1);
    vecs[4]  = mk(0, 16'h0000, 8'h00, 0,  1, 4'd10, 0, 0, 5'd1, 8'h3C, 0, 1);
    vecs[5]  = mk(0, 16'h0000, 8'h00, 0,  1, 4'd10, 0, 0, 5'd1, 8'h3C, 0, 1);
    vecs[6]  = mk(0, 16'h0000, 8'h00, 1,  1, 4'd10, 0, 0, 5'd1, 8'h3C, 0, 1);
    vecs[7]  = mk(0, 16'h0000, 8'h00, 1,  1, 4'd5,  0, 0, 5'd2, 8'h3C, 0, 1);
    vecs[8]  = mk(0, 16'h0000, 8'h00, 1,  1, 4'd0,  1, 0, 5'd3, 8'h3C, 1, 1);
    vecs[9]  = mk(1, 16'h0000, 8'h55, 1,  0, 4'd0,  0, 0, 5'd0, 8'h00, 1, 0);
    vecs[10] = mk(0, 16'h0000, 8'h00, 1,  1, 4'd0,  1, 1, 5'd0, 8'h55, 1, 1);
    vecs[11] = mk(0, 16'h0000, 8'h00, 1,  0, 4'd0,  0, 0, 5'd0, 8'h00, 1, 0);
    vecs[12] = mk(1, 16'h0300, 8'h11, 1,  0, 4'd0,  0, 0, 5'd0, 8'h00, 1, 0);
    vecs[13] = mk(1, 16'h1234, 8'hAA, 1,  1, 4'd9,  0, 0, 5'd0, 8'h11, 0, 1);
    vecs[14] = mk(0, 16'h0000, 8'h00, 1,  1, 4'd8,  1, 0, 5'd1, 8'h11, 1, 1);
    vecs[15] = mk(0, 16'h0000, 8'h00, 1,  0, 4'd0,  0, 0, 5'd0, 8'h00, 1, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].iv, vecs[i].m, vecs[i].t, vecs[i].ordy);
      check($sformatf("v%0d.valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d.pos",   i), 32'(out_pos),   32'(vecs[i].ep));
      check($sformatf("v%0d.last",  i), 32'(out_last),  32'(vecs[i].el));
      check($sformatf("v%0d.zero",  i), 32'(out_zero),  32'(vecs[i].ez));
      check($sformatf("v%0d.idx",   i), 32'(out_idx),   32'(vecs[i].ei));
      check($sformatf("v%0d.tag",   i), 32'(out_tag),   32'(vecs[i].et));
      check($sformatf("v%0d.ready", i), 32'(in_ready),  32'(vecs[i].eir));
      check($sformatf("v%0d.busy",  i), 32'(busy),      32'(vecs[i].eb));
    end

    // Full mask followed back-to-back by 0x0001 with in_valid held high.
    drive(1'b1, 16'hFFFF, 8'h77, 1'b1);
    check("full.load_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 16'h0001, 8'h78, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i != 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("full%0d.valid", i), 32'(out_valid), 32'd1);
      check($sformatf("full%0d.pos",   i), 32'(out_pos),   32'(15 - i));
      check($sformatf("full%0d.idx",   i), 32'(out_idx),   32'(i));
      check($sformatf("full%0d.last",  i), 32'(out_last),  32'(i == 15));
      check($sformatf("full%0d.ready", i), 32'(in_ready),  32'(i == 15));
      check($sformatf("full%0d.tag",   i), 32'(out_tag),   32'h77);
    end
    drive(1'b0, 16'h0000, 8'h00, 1'b1);
    check("b2b.valid", 32'(out_valid), 32'd1);
    check("b2b.pos",   32'(out_pos),   32'd0);
    check("b2b.last",  32'(out_last),  32'd1);
    check("b2b.zero",  32'(out_zero),  32'd0);
    check("b2b.idx",   32'(out_idx),   32'd0);
    check("b2b.tag",   32'(out_tag),   32'h78);
    drive(1'b0, 16'h0000, 8'h00, 1'b1);
    check_idle("b2b.after");

    // Reset in the middle of a scan discards the remaining beats.
    drive(1'b1, 16'h00F0, 8'h21, 1'b1);
    drive(1'b0, 16'h0000, 8'h00, 1'b1);
    check("rst.pos7", 32'(out_pos), 32'd7);
    drive(1'b0, 16'h0000, 8'h00, 1'b1);
    check("rst.pos6", 32'(out_pos), 32'd6);
    check("rst.idx1", 32'(out_idx), 32'd1);
    drive(1'b0, 16'h0000, 8'h00, 1'b0);
    reset = 1'b1;
    drive(1'b0, 16'h0000, 8'h00, 1'b1);
    check_idle("rst.in_reset");
    check("rst.tag", 32'(out_tag), 32'd0);
    reset = 1'b0;
    drive(1'b0, 16'h0000, 8'h00, 1'b1);
    check_idle("rst.released");
    drive(1'b1, 16'h0002, 8'h42, 1'b1);
    drive(1'b0, 16'h0000, 8'h00, 1'b1);
    check("rst.new.valid", 32'(out_valid), 32'd1);
    check("rst.new.pos",   32'(out_pos),   32'd1);
    check("rst.new.last",  32'(out_last),  32'd1);
    check("rst.new.idx",   32'(out_idx),   32'd0);
    check("rst.new.tag",   32'(out_tag),   32'h42);
    drive(1'b0, 16'h0000, 8'h00, 1'b1);
    check_idle("rst.new.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
